// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Watches N_CH level inputs for enabled rising/falling edges, keeps one
//   pending event per channel, and hands events to a single-entry output slot
//   with round-robin selection across channels.
//
// Ports
//   clk, rst      : clock and synchronous active-high reset
//   signal_i      : per-channel levels, already synchronous to clk
//   rise_en_i     : per-channel rising-edge enables
//   fall_en_i     : per-channel falling-edge enables
//   evt_valid_o   : output slot holds an event
//   evt_ready_i   : consumer accept (transfer when valid & ready)
//   evt_ch_o      : channel index of the presented event
//   evt_type_o    : edge type of the presented event (1 = rising, 0 = falling)
//   pending_o     : per-channel pending-event bits
//   ovf_o         : per-channel sticky overflow flags
//   ovf_clr_i     : clears all overflow flags (a same-cycle new overflow wins)
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] signal_i,
  input  logic [N_CH-1:0] rise_en_i,
  input  logic [N_CH-1:0] fall_en_i,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [CH_W-1:0] evt_ch_o,
  output logic            evt_type_o,
  output logic [N_CH-1:0] pending_o,
  output logic [N_CH-1:0] ovf_o,
  input  logic            ovf_clr_i
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t     state;
  logic [N_CH-1:0] prev;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] ptype;
  logic [N_CH-1:0] ovf;
  logic [CH_W-1:0] ch;
  logic            etype;
  logic [CH_W-1:0] rr_ptr;

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] edge_det;
  logic            xfer;
  logic            can_load;
  logic            gnt_found;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt;
  logic [N_CH-1:0] grant_mask;
  logic [N_CH-1:0] still_pending;
  logic [N_CH-1:0] ovf_set;
  logic [N_CH-1:0] load_evt;
  logic [N_CH-1:0] pending_nxt;
  logic [N_CH-1:0] ptype_nxt;
  logic [N_CH-1:0] ovf_nxt;
  logic [CH_W-1:0] rr_nxt;

  assign rise     = signal_i & ~prev & rise_en_i;
  assign fall     = ~signal_i & prev & fall_en_i;
  assign edge_det = rise | fall;

  assign xfer     = (state == FULL) & evt_ready_i;
  assign can_load = (state == EMPTY) | xfer;

  // Round-robin search: first pending channel at or after rr_ptr, wrapping.
  always_comb begin
    int c;
    c         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= N_CH) begin
        c = c - N_CH;
      end else begin
        c = c;
      end
      if (!gnt_found && pending[CH_W'(c)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(c);
      end else begin
        gnt_found = gnt_found;
      end
    end
  end

  assign gnt        = can_load & gnt_found;
  assign grant_mask = gnt ? (N_CH'(1) << gnt_idx) : '0;

  // A channel whose event is granted this cycle is free to accept a new edge;
  // otherwise a new edge on a pending channel is dropped and flagged.
  assign still_pending = pending & ~grant_mask;
  assign ovf_set       = edge_det & still_pending;
  assign load_evt      = edge_det & ~still_pending;
  assign pending_nxt   = still_pending | edge_det;
  assign ptype_nxt     = (ptype & ~load_evt) | (rise & load_evt);
  assign ovf_nxt       = (ovf & ~{N_CH{ovf_clr_i}}) | ovf_set;
  assign rr_nxt        = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);

  // Edge history, pending/overflow state, and the output-slot FSM.
  always_ff @(posedge clk) begin
    prev <= signal_i;
    if (rst) begin
      pending <= '0;
      ptype   <= '0;
      ovf     <= '0;
      state   <= EMPTY;
      ch      <= '0;
      etype   <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      pending <= pending_nxt;
      ptype   <= ptype_nxt;
      ovf     <= ovf_nxt;
      case (state)
        EMPTY: begin
          if (gnt) begin
            state  <= FULL;
            ch     <= gnt_idx;
            etype  <= ptype[gnt_idx];
            rr_ptr <= rr_nxt;
          end else begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (gnt) begin
            state  <= FULL;
            ch     <= gnt_idx;
            etype  <= ptype[gnt_idx];
            rr_ptr <= rr_nxt;
          end else if (xfer) begin
            state <= EMPTY;
          end else begin
            state <= FULL;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  assign evt_valid_o = (state == FULL);
  assign evt_ch_o    = ch;
  assign evt_type_o  = etype;
  assign pending_o   = pending;
  assign ovf_o       = ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter
//   Directed scenarios followed by randomized stimulus, all checked every
//   cycle against a behavioural model of pending events, overflow flags and
//   the output slot.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] signal_i;
  logic [N-1:0] rise_en_i;
  logic [N-1:0] fall_en_i;
  logic         evt_valid_o;
  logic         evt_ready_i;
  logic [1:0]   evt_ch_o;
  logic         evt_type_o;
  logic [N-1:0] pending_o;
  logic [N-1:0] ovf_o;
  logic         ovf_clr_i;

  int n_checks;
  int n_errors;

  // behavioural model state
  bit m_prev  [N];
  bit m_pend  [N];
  bit m_ptype [N];
  bit m_ovf   [N];
  bit m_valid;
  bit m_type;
  int m_ch;
  int m_rr;

  edge_event_arbiter #(.N_CH(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .signal_i   (signal_i),
    .rise_en_i  (rise_en_i),
    .fall_en_i  (fall_en_i),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_ch_o   (evt_ch_o),
    .evt_type_o (evt_type_o),
    .pending_o  (pending_o),
    .ovf_o      (ovf_o),
    .ovf_clr_i  (ovf_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pack(input bit v [N]);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) r = r | (int'(v[i]) << i);
    return r;
  endfunction

  // Advance the model by one clock using the inputs visible at the edge.
  task automatic model_step();
    int g;
    int c;
    bit r;
    bit f;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = signal_i[i];
        m_pend[i] = 0; m_ptype[i] = 0; m_ovf[i] = 0;
      end
      m_valid = 0; m_ch = 0; m_type = 0; m_rr = 0;
      return;
    end
    g = -1;
    if (!m_valid || evt_ready_i) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (g < 0 && m_pend[c]) g = c;
      end
      if (g >= 0) begin
        m_valid = 1; m_ch = g; m_type = m_ptype[g];
        m_pend[g] = 0; m_rr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    if (ovf_clr_i) for (int i = 0; i < N; i++) m_ovf[i] = 0;
    for (int i = 0; i < N; i++) begin
      r = signal_i[i] && !m_prev[i] && rise_en_i[i];
      f = !signal_i[i] && m_prev[i] && fall_en_i[i];
      if (r || f) begin
        if (m_pend[i]) m_ovf[i] = 1;
        else begin m_pend[i] = 1; m_ptype[i] = r; end
      end
      m_prev[i] = signal_i[i];
    end
  endtask

  // One clock: model update at the edge, compare DUT #1 later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_eq("valid", int'(evt_valid_o), int'(m_valid));
    check_eq("pending", int'(pending_o), pack(m_pend));
    check_eq("ovf", int'(ovf_o), pack(m_ovf));
    if (m_valid) begin
      check_eq("ch", int'(evt_ch_o), m_ch);
      check_eq("type", int'(evt_type_o), int'(m_type));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0; m_pend[i] = 0; m_ptype[i] = 0; m_ovf[i] = 0;
    end
    m_valid = 0; m_ch = 0; m_type = 0; m_rr = 0;

    // Reset with all inputs high, then release: no spurious events.
    rst = 1'b1; signal_i = 4'hF; rise_en_i = 4'hF; fall_en_i = 4'hF;
    evt_ready_i = 1'b1; ovf_clr_i = 1'b0;
    cyc(); cyc();
    check_eq("rst_valid", int'(evt_valid_o), 0);
    check_eq("rst_ch", int'(evt_ch_o), 0);
    check_eq("rst_type", int'(evt_type_o), 0);
    check_eq("rst_pend", int'(pending_o), 0);
    check_eq("rst_ovf", int'(ovf_o), 0);
    rst = 1'b0;
    cyc(); cyc(); cyc();
    check_eq("post_rst_valid", int'(evt_valid_o), 0);
    check_eq("post_rst_pend", int'(pending_o), 0);

    // Single rising edge on ch2.
    rise_en_i = 4'b0000; fall_en_i = 4'b0000; signal_i = 4'b0000;
    cyc(); cyc();
    rise_en_i = 4'b0100; signal_i = 4'b0100;
    cyc();
    check_eq("single_not_yet", int'(evt_valid_o), 0);
    cyc();
    check_eq("single_valid", int'(evt_valid_o), 1);
    check_eq("single_ch", int'(evt_ch_o), 2);
    check_eq("single_type", int'(evt_type_o), 1);
    cyc();
    check_eq("single_one_cycle", int'(evt_valid_o), 0);

    // Round-robin ordering from rr_ptr = 0.
    signal_i = 4'b0000; rst = 1'b1; cyc(); rst = 1'b0; cyc();
    rise_en_i = 4'hF; signal_i = 4'b1011;
    cyc();
    cyc(); check_eq("rr_first", int'(evt_ch_o), 0);
    cyc(); check_eq("rr_second", int'(evt_ch_o), 1);
    cyc(); check_eq("rr_third", int'(evt_ch_o), 3);
    signal_i = 4'b0000; cyc(); cyc();
    signal_i = 4'b1001; cyc();
    cyc(); check_eq("rr2_first", int'(evt_ch_o), 0);
    cyc(); check_eq("rr2_second", int'(evt_ch_o), 3);

    // Backpressure: ch1 rises and falls twice with the consumer stalled.
    rise_en_i = 4'b0000; signal_i = 4'b0000; cyc(); cyc();
    evt_ready_i = 1'b0; rise_en_i = 4'b0010; fall_en_i = 4'b0010;
    signal_i = 4'b0010; cyc();
    signal_i = 4'b0000; cyc();
    signal_i = 4'b0010; cyc();
    signal_i = 4'b0000; cyc();
    check_eq("bp_valid", int'(evt_valid_o), 1);
    check_eq("bp_ch", int'(evt_ch_o), 1);
    check_eq("bp_type", int'(evt_type_o), 1);
    check_eq("bp_pend", int'(pending_o[1]), 1);
    check_eq("bp_ovf", int'(ovf_o[1]), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("bp_hold_ch", int'(evt_ch_o), 1);
      check_eq("bp_hold_type", int'(evt_type_o), 1);
    end
    evt_ready_i = 1'b1; cyc();
    check_eq("bp_next_type", int'(evt_type_o), 0);
    cyc();
    ovf_clr_i = 1'b1; cyc(); ovf_clr_i = 1'b0;

    // Pop-and-arrive: a one-cycle pulse on ch0 delivers rise then fall.
    rise_en_i = 4'b0001; fall_en_i = 4'b0001;
    signal_i = 4'b0001; cyc();
    signal_i = 4'b0000; cyc();
    check_eq("pa_rise_valid", int'(evt_valid_o), 1);
    check_eq("pa_rise_type", int'(evt_type_o), 1);
    cyc();
    check_eq("pa_fall_ch", int'(evt_ch_o), 0);
    check_eq("pa_fall_type", int'(evt_type_o), 0);
    check_eq("pa_ovf", int'(ovf_o), 0);
    cyc();

    // Clear collides with a new ch3 overflow while ovf[2] is set.
    evt_ready_i = 1'b0; rise_en_i = 4'b1100; fall_en_i = 4'b1100;
    signal_i = 4'b0100; cyc();
    signal_i = 4'b0000; cyc();
    signal_i = 4'b0100; cyc();
    check_eq("clr_pre_ovf", int'(ovf_o), 4'b0100);
    signal_i = 4'b1100; cyc();
    signal_i = 4'b0100; ovf_clr_i = 1'b1; cyc();
    check_eq("clr_collide", int'(ovf_o), 4'b1000);
    ovf_clr_i = 1'b0;

    // Reset while the slot is full discards it.
    check_eq("full_before_rst", int'(evt_valid_o), 1);
    rst = 1'b1; cyc();
    check_eq("rst_full_valid", int'(evt_valid_o), 0);
    check_eq("rst_full_pend", int'(pending_o), 0);
    rst = 1'b0; cyc();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      signal_i    = 4'($urandom);
      rise_en_i   = 4'($urandom) | 4'($urandom);
      fall_en_i   = 4'($urandom) | 4'($urandom);
      evt_ready_i = ($urandom_range(0, 3) != 0);
      ovf_clr_i   = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
